el2_exu_div_noc_client: RTL

EXU-side NoC endpoint for the remote divider node. Captures a divide request from the EXU (`dp`, operands, `cancel`), serializes it into flits onto the NoC, then collects and reassembles the 32-bit result flits returned by the divider node and presents them as `out` with a one-cycle `finish_dly` strobe. It also turns a pipeline `cancel` into an abort packet and discards stale results. It is the direct upstream producer and downstream consumer of the divider NoC node.

---
 rtl/noc_types.sv | 37 +++
 rtl/node_port.sv | 12 +
 rtl/noc_flit_deserializer.sv | 55 +++++
 rtl/el2_exu_div_noc_client.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/noc_types.sv
// rtl/noc_types.sv - shared NoC flit, divider packet and core parameter types
package noc_types;

  localparam int NOC_FLIT_BITS = 16;
  localparam int NOC_ADDR_BITS = 4;
  localparam logic [NOC_ADDR_BITS-1:0] POS_DIV_NODE = 4'd3;

  // Request is {dp(3), cancel(1), dividend(32), divisor(32)}
  localparam int DIV_REQ_BITS = 68;
  localparam int DIV_RSP_BITS = 32;

  typedef struct packed {
    logic [NOC_ADDR_BITS-1:0] dst;
    logic                     last;
    logic [NOC_FLIT_BITS-1:0] payload;
  } flit_t;

  typedef struct packed {
    logic valid;
    logic unsign;
    logic rem;
  } el2_div_pkt_t;

  // Core parameter set; only the flush counter floor is consumed here
  typedef struct packed {
    logic [7:0] div_cnt_bits;
  } el2_param_t;

  function automatic int req_flits(input int fb);
    return (DIV_REQ_BITS + fb - 1) / fb;
  endfunction

  function automatic int rsp_flits(input int fb);
    return (DIV_RSP_BITS + fb - 1) / fb;
  endfunction

endpackage

// File: rtl/node_port.sv
// rtl/node_port.sv - one-direction NoC flit link with producer and consumer views
interface node_port;
  import noc_types::*;

  logic  valid;
  logic  ready;
  flit_t flit;

  modport up   (output valid, output flit, input ready);
  modport down (input valid, input flit, output ready);

endinterface

// File: rtl/noc_flit_deserializer.sv
// rtl/noc_flit_deserializer.sv - reassembles an N-flit packet, MSB flit first
module noc_flit_deserializer #(
  parameter int FB = 16,
  parameter int N  = 2
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          clear,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic [FB-1:0] in_data,
  output logic          done,
  output logic [N*FB-1:0] data
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q;

  // The packet ends on its tagged last flit, or when N flits have arrived
  assign done = in_valid && (in_last || (cnt_q == CNT_LAST));

  if (N > 1) begin : g_shift
    logic [(N-1)*FB-1:0] sh_q;

    // The word presented on done already includes the flit arriving now
    assign data = {sh_q, in_data};

    // Shift earlier flits towards the MSB end; drop partial packets on clear
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        sh_q <= '0;
      end else if (clear || done) begin
        sh_q <= '0;
      end else if (in_valid) begin
        sh_q <= data[(N-1)*FB-1:0];
      end
    end
  end else begin : g_single
    assign data = in_data;
  end

  // Flit position within the current packet
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q <= '0;
    end else if (clear || done) begin
      cnt_q <= '0;
    end else if (in_valid) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/el2_exu_div_noc_client.sv
// rtl/el2_exu_div_noc_client.sv - EXU endpoint serializing divides to the remote divider node
module el2_exu_div_noc_client
  import noc_types::*;
#(
  parameter el2_param_t              pt           = '0,
  parameter int                      FLIT_BITS    = NOC_FLIT_BITS,
  parameter logic [NOC_ADDR_BITS-1:0] DIV_ADDR    = POS_DIV_NODE,
  parameter int                      FLUSH_CYCLES = 8
) (
  input  logic         clk,
  input  logic         rst_l,
  input  el2_div_pkt_t dp,
  input  logic [31:0]  dividend,
  input  logic [31:0]  divisor,
  input  logic         cancel,
  output logic [31:0]  out,
  output logic         finish_dly,
  output logic         div_busy,
  node_port.up         up,
  node_port.down       down
);

  localparam int REQ_FLITS = req_flits(FLIT_BITS);
  localparam int RSP_FLITS = rsp_flits(FLIT_BITS);
  localparam int REQ_W     = REQ_FLITS * FLIT_BITS;
  localparam int RSP_W     = RSP_FLITS * FLIT_BITS;
  localparam int RCW       = (REQ_FLITS > 1) ? $clog2(REQ_FLITS) : 1;
  localparam int FCW_MIN   = $clog2(FLUSH_CYCLES + 1);
  localparam int PT_CNT    = int'(pt.div_cnt_bits);
  localparam int FCW       = (PT_CNT > FCW_MIN) ? PT_CNT : FCW_MIN;

  localparam logic [RCW-1:0] REQ_LAST   = RCW'(REQ_FLITS - 1);
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    CSEND,
    FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic [REQ_W-1:0] req_q;
  logic [RCW-1:0]   flit_cnt_q;
  logic [FCW-1:0]   flush_cnt_q;
  logic             cancel_seen_q;
  logic [31:0]      out_q;
  logic             finish_q;

  logic             load_req, load_abort, load_out;
  logic             up_fire, flit_last;
  logic             rsp_done;
  logic [RSP_W-1:0] rsp_data;

  assign up_fire   = up.valid && up.ready;
  assign flit_last = (flit_cnt_q == REQ_LAST);

  // Both request and abort packets leave from the top of the same shift register
  assign up.valid        = (state_q == SEND) || (state_q == CSEND);
  assign up.flit.dst     = DIV_ADDR;
  assign up.flit.last    = flit_last;
  assign up.flit.payload = NOC_FLIT_BITS'(req_q[REQ_W-1 -: FLIT_BITS]);

  // Responses outside WAIT are stale or unsolicited and are simply sunk
  assign down.ready = 1'b1;

  assign out        = out_q;
  assign finish_dly = finish_q;
  assign div_busy   = (state_q != IDLE);

  noc_flit_deserializer #(
    .FB (FLIT_BITS),
    .N  (RSP_FLITS)
  ) u_rsp_deser (
    .clk      (clk),
    .rst_l    (rst_l),
    .clear    (state_q != WAIT),
    .in_valid (down.valid && (state_q == WAIT)),
    .in_last  (down.flit.last),
    .in_data  (down.flit.payload[FLIT_BITS-1:0]),
    .done     (rsp_done),
    .data     (rsp_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath load strobes; packets always run to their last flit
  always_comb begin
    state_d    = state_q;
    load_req   = 1'b0;
    load_abort = 1'b0;
    load_out   = 1'b0;
    case (state_q)
      IDLE: begin
        if (dp.valid && !cancel) begin
          state_d  = SEND;
          load_req = 1'b1;
        end
      end
      SEND: begin
        if (up_fire && flit_last) begin
          if (cancel_seen_q || cancel) begin
            state_d    = CSEND;
            load_abort = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cancel) begin
          // A result completing under cancel is discarded with no abort needed
          state_d    = rsp_done ? IDLE : CSEND;
          load_abort = !rsp_done;
        end else if (rsp_done) begin
          state_d  = IDLE;
          load_out = 1'b1;
        end
      end
      CSEND: begin
        if (up_fire && flit_last) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Packet shift register, flit/flush counters, sticky cancel and result register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      req_q         <= '0;
      flit_cnt_q    <= '0;
      flush_cnt_q   <= '0;
      cancel_seen_q <= 1'b0;
      out_q         <= '0;
      finish_q      <= 1'b0;
    end else begin
      finish_q <= load_out;
      if (load_out) begin
        out_q <= rsp_data[31:0];
      end
      if ((state_q == SEND) && cancel) begin
        cancel_seen_q <= 1'b1;
      end
      if (load_req) begin
        req_q         <= REQ_W'({dp, 1'b0, dividend, divisor});
        flit_cnt_q    <= '0;
        cancel_seen_q <= 1'b0;
      end else if (load_abort) begin
        req_q         <= REQ_W'({3'b000, 1'b1, 64'd0});
        flit_cnt_q    <= '0;
        cancel_seen_q <= 1'b0;
      end else if (up_fire) begin
        req_q      <= req_q << FLIT_BITS;
        flit_cnt_q <= flit_last ? '0 : flit_cnt_q + 1'b1;
      end
      flush_cnt_q <= (state_q == FLUSH) ? flush_cnt_q + 1'b1 : '0;
    end
  end

endmodule
